// File: rtl/dual_syn_ram_cfg.sv
// True dual-port synchronous RAM with a post-reset clear sweep, selectable
// read-during-write behaviour, optional output register and collision flag.
module dual_syn_ram_cfg #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_BUS  = 4,
  parameter int READ_MODE = 0,
  parameter int OUT_REG   = 0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                busy,
  input  logic                a_we,
  input  logic                a_re,
  input  logic [ADDR_BUS-1:0] a_addr,
  input  logic [WIDTH-1:0]    a_din,
  output logic [WIDTH-1:0]    a_dout,
  output logic                a_valid,
  input  logic                b_we,
  input  logic                b_re,
  input  logic [ADDR_BUS-1:0] b_addr,
  input  logic [WIDTH-1:0]    b_din,
  output logic [WIDTH-1:0]    b_dout,
  output logic                b_valid,
  output logic                collision
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state, state_nx;
  logic [ADDR_BUS-1:0] cnt;
  logic [WIDTH-1:0]    mem [DEPTH];

  logic ready, same_addr, a_wr, b_wr, a_rd, b_rd;
  logic [WIDTH-1:0] a_rdata, b_rdata;
  logic [WIDTH-1:0] a_q1, b_q1;
  logic             a_v1, b_v1;

  assign ready     = (state == READY);
  assign busy      = ~ready;
  assign same_addr = (a_addr == b_addr);
  assign a_wr      = ready & a_we;
  // On a same-address double write, port A wins and B's write is dropped.
  assign b_wr      = ready & b_we & ~(a_we & same_addr);
  assign a_rd      = ready & a_re;
  assign b_rd      = ready & b_re;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (cnt == ADDR_BUS'(DEPTH - 1)) state_nx = READY;
      READY:   state_nx = READY;
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      if (a_wr) mem[a_addr] <= a_din;
      if (b_wr) mem[b_addr] <= b_din;
    end
  end

  always_comb begin
    a_rdata = mem[a_addr];
    b_rdata = mem[b_addr];
    if (READ_MODE == 1) begin
      if (a_wr)                   a_rdata = a_din;
      else if (b_wr && same_addr) a_rdata = b_din;
      if (a_wr && same_addr)      b_rdata = a_din;
      else if (b_wr)              b_rdata = b_din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q1      <= '0;
      b_q1      <= '0;
      a_v1      <= 1'b0;
      b_v1      <= 1'b0;
      collision <= 1'b0;
    end else begin
      a_v1      <= a_rd;
      b_v1      <= b_rd;
      collision <= ready & a_we & b_we & same_addr;
      if (a_rd) a_q1 <= a_rdata;
      if (b_rd) b_q1 <= b_rdata;
    end
  end

  if (OUT_REG == 1) begin : g_out_reg
    logic [WIDTH-1:0] a_q2, b_q2;
    logic             a_v2, b_v2;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        a_q2 <= '0;
        b_q2 <= '0;
        a_v2 <= 1'b0;
        b_v2 <= 1'b0;
      end else begin
        a_v2 <= a_v1;
        b_v2 <= b_v1;
        if (a_v1) a_q2 <= a_q1;
        if (b_v1) b_q2 <= b_q1;
      end
    end

    assign a_dout  = a_q2;
    assign b_dout  = b_q2;
    assign a_valid = a_v2;
    assign b_valid = b_v2;
  end else begin : g_no_out_reg
    assign a_dout  = a_q1;
    assign b_dout  = b_q1;
    assign a_valid = a_v1;
    assign b_valid = b_v1;
  end

endmodule

// File: tb/tb_dual_syn_ram_cfg.sv
// Bench: two instances (read-first/no out reg, write-first/out reg) driven by
// the same directed vectors, each checked against hand-computed values.
module tb_dual_syn_ram_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_we = 1'b0, a_re = 1'b0, b_we = 1'b0, b_re = 1'b0;
  logic [3:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_din = '0, b_din = '0;

  logic       busy0, a_valid0, b_valid0, collision0;
  logic [7:0] a_dout0, b_dout0;
  logic       busy1, a_valid1, b_valid1, collision1;
  logic [7:0] a_dout1, b_dout1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dual_syn_ram_cfg #(.WIDTH(8), .DEPTH(16), .ADDR_BUS(4), .READ_MODE(0), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .busy(busy0),
    .a_we(a_we), .a_re(a_re), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout0), .a_valid(a_valid0),
    .b_we(b_we), .b_re(b_re), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout0), .b_valid(b_valid0),
    .collision(collision0)
  );

  dual_syn_ram_cfg #(.WIDTH(8), .DEPTH(16), .ADDR_BUS(4), .READ_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .busy(busy1),
    .a_we(a_we), .a_re(a_re), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout1), .a_valid(a_valid1),
    .b_we(b_we), .b_re(b_re), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout1), .b_valid(b_valid1),
    .collision(collision1)
  );

  typedef struct {
    logic       a_we, a_re;
    logic [3:0] a_addr;
    logic [7:0] a_din;
    logic       b_we, b_re;
    logic [3:0] b_addr;
    logic [7:0] b_din;
    logic       ea_v;
    logic [7:0] ea0, ea1;
    logic       eb_v;
    logic [7:0] eb0, eb1;
    logic       ecol;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    a_we = 1'b0; a_re = 1'b0; b_we = 1'b0; b_re = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " busy0"}, busy0, 1);         chk({tag, " busy1"}, busy1, 1);
    chk({tag, " a_dout0"}, a_dout0, 0);     chk({tag, " a_dout1"}, a_dout1, 0);
    chk({tag, " b_dout0"}, b_dout0, 0);     chk({tag, " b_dout1"}, b_dout1, 0);
    chk({tag, " a_valid0"}, a_valid0, 0);   chk({tag, " a_valid1"}, a_valid1, 0);
    chk({tag, " b_valid0"}, b_valid0, 0);   chk({tag, " b_valid1"}, b_valid1, 0);
    chk({tag, " col0"}, collision0, 0);     chk({tag, " col1"}, collision1, 0);
  endtask

  // Counts edges until busy drops (bounded); no read may complete meanwhile.
  task automatic count_busy(input string tag);
    int n = 0;
    int v = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (a_valid0 || a_valid1 || b_valid0 || b_valid1) v++;
      if (!busy0) break;
    end
    chk({tag, " busy cycles"}, n, 16);
    chk({tag, " busy1 low"}, busy1, 0);
    chk({tag, " valid during sweep"}, v, 0);
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("vec%0d", idx);
    a_we = v.a_we; a_re = v.a_re; a_addr = v.a_addr; a_din = v.a_din;
    b_we = v.b_we; b_re = v.b_re; b_addr = v.b_addr; b_din = v.b_din;
    @(posedge clk); #1;
    idle_inputs();
    chk({t, " col0"}, collision0, v.ecol);
    chk({t, " col1"}, collision1, v.ecol);
    chk({t, " a_valid0"}, a_valid0, v.ea_v);
    chk({t, " b_valid0"}, b_valid0, v.eb_v);
    if (v.ea_v) chk({t, " a_dout0"}, a_dout0, v.ea0);
    if (v.eb_v) chk({t, " b_dout0"}, b_dout0, v.eb0);
    chk({t, " a_valid1 early"}, a_valid1, 0);
    chk({t, " b_valid1 early"}, b_valid1, 0);
    @(posedge clk); #1;
    chk({t, " a_valid1"}, a_valid1, v.ea_v);
    chk({t, " b_valid1"}, b_valid1, v.eb_v);
    if (v.ea_v) chk({t, " a_dout1"}, a_dout1, v.ea1);
    if (v.eb_v) chk({t, " b_dout1"}, b_dout1, v.eb1);
    chk({t, " a_valid0 pulse"}, a_valid0, 0);
    chk({t, " col0 pulse"}, collision0, 0);
  endtask

  function automatic vec_t mk(
    input logic awe, input logic are, input logic [3:0] aa, input logic [7:0] ad,
    input logic bwe, input logic bre, input logic [3:0] ba, input logic [7:0] bd,
    input logic eav, input logic [7:0] ea0, input logic [7:0] ea1,
    input logic ebv, input logic [7:0] eb0, input logic [7:0] eb1, input logic ecol);
    vec_t v;
    v.a_we = awe; v.a_re = are; v.a_addr = aa; v.a_din = ad;
    v.b_we = bwe; v.b_re = bre; v.b_addr = ba; v.b_din = bd;
    v.ea_v = eav; v.ea0 = ea0; v.ea1 = ea1;
    v.eb_v = ebv; v.eb0 = eb0; v.eb1 = eb1; v.ecol = ecol;
    return v;
  endfunction

  initial begin
    vec_t v;
    //            awe are aa  ad     bwe bre ba  bd     eav ea0    ea1    ebv eb0    eb1    col
    vt[0]  = mk(0, 1, 5,  8'h00, 0, 0, 0,  8'h00, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    vt[1]  = mk(1, 0, 3,  8'hA5, 0, 0, 0,  8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    vt[2]  = mk(0, 0, 0,  8'h00, 0, 1, 3,  8'h00, 0, 8'h00, 8'h00, 1, 8'hA5, 8'hA5, 0);
    vt[3]  = mk(1, 0, 7,  8'h11, 0, 0, 0,  8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    vt[4]  = mk(1, 0, 7,  8'h22, 0, 1, 7,  8'h00, 0, 8'h00, 8'h00, 1, 8'h11, 8'h22, 0);
    vt[5]  = mk(0, 0, 0,  8'h00, 0, 1, 7,  8'h00, 0, 8'h00, 8'h00, 1, 8'h22, 8'h22, 0);
    vt[6]  = mk(1, 0, 9,  8'h3C, 1, 0, 9,  8'hC3, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
    vt[7]  = mk(0, 1, 9,  8'h00, 0, 1, 9,  8'h00, 1, 8'h3C, 8'h3C, 1, 8'h3C, 8'h3C, 0);
    vt[8]  = mk(0, 1, 4,  8'h00, 1, 0, 4,  8'h5A, 1, 8'h00, 8'h5A, 0, 8'h00, 8'h00, 0);
    vt[9]  = mk(1, 1, 2,  8'h77, 0, 0, 0,  8'h00, 1, 8'h00, 8'h77, 0, 8'h00, 8'h00, 0);
    vt[10] = mk(1, 0, 10, 8'h10, 1, 0, 11, 8'h20, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    vt[11] = mk(0, 1, 10, 8'h00, 0, 1, 11, 8'h00, 1, 8'h10, 8'h10, 1, 8'h20, 8'h20, 0);
    vt[12] = mk(1, 0, 6,  8'h99, 1, 1, 6,  8'h66, 0, 8'h00, 8'h00, 1, 8'h00, 8'h99, 1);
    vt[13] = mk(0, 1, 6,  8'h00, 0, 1, 6,  8'h00, 1, 8'h99, 8'h99, 1, 8'h99, 8'h99, 0);

    #3;
    check_reset_outputs("reset");
    a_re = 1'b1; a_addr = 4'd5;
    @(negedge clk); rst = 1'b1;
    count_busy("sweep");
    idle_inputs();

    for (int i = 0; i < 14; i++) apply_vec(i, vt[i]);

    // Fill with addr^0xFF, then stream 16 back-to-back reads on port A.
    for (int k = 0; k < 16; k++) begin
      a_we = 1'b1; a_addr = 4'(k); a_din = 8'(k) ^ 8'hFF;
      @(posedge clk); #1;
    end
    a_we = 1'b0;
    for (int k = 0; k < 18; k++) begin
      a_re = (k < 16); a_addr = 4'(k);
      @(posedge clk); #1;
      chk($sformatf("stream%0d a_valid0", k), a_valid0, (k < 16));
      chk($sformatf("stream%0d a_dout0", k), a_dout0, (k < 16) ? (8'(k) ^ 8'hFF) : 8'hF0);
      chk($sformatf("stream%0d a_valid1", k), a_valid1, (k >= 1 && k < 17));
      if (k >= 1) chk($sformatf("stream%0d a_dout1", k), a_dout1, (k < 17) ? (8'(k - 1) ^ 8'hFF) : 8'hF0);
    end
    idle_inputs();

    // Reset during an in-flight read, then again in the middle of the sweep.
    a_we = 1'b1; a_addr = 4'd12; a_din = 8'hAB;
    @(posedge clk); #1;
    a_we = 1'b0; a_re = 1'b1;
    @(posedge clk); #1;
    a_re = 1'b0;
    chk("pre-rst a_valid0", a_valid0, 1);
    chk("pre-rst a_dout0", a_dout0, 8'hAB);
    #1 rst = 1'b0;
    #1 check_reset_outputs("rst mid-read");
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst hold a_valid1", a_valid1, 0);
      chk("rst hold a_dout1", a_dout1, 0);
    end
    @(negedge clk); rst = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("mid-sweep busy0", busy0, 1);
    rst = 1'b0;
    #1 check_reset_outputs("rst mid-sweep");
    @(negedge clk); rst = 1'b1;
    count_busy("resweep");
    v = mk(0, 1, 12, 8'h00, 0, 1, 12, 8'h00, 1, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0);
    apply_vec(14, v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dual_syn_ram_cfg.md
Name: dual_syn_ram_cfg

Overview:
- Parametrised true dual-port synchronous RAM; next generation of the team's single-port synchronous RAM.
- Two independent read/write ports (A, B) share one memory array.
- Separate din/dout buses replace the bidirectional data bus.
- Adds: selectable read-during-write mode, optional output register, write-write collision detection, and a post-reset hardware clear sweep.
- Used as a generic buffer/scratchpad under FIFOs and register files.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of words; must equal 2**ADDR_BUS.
- ADDR_BUS, 4, address width in bits.
- READ_MODE, 0, read-during-write result: 0 = read-first (old data), 1 = write-first (new data).
- OUT_REG, 0, 1 = extra output pipeline stage (read latency 2 instead of 1).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- busy  output  1  high while the clear sweep runs; port requests are ignored.
- a_we  input  1  port A write enable.
- a_re  input  1  port A read enable.
- a_addr  input  ADDR_BUS  port A address.
- a_din  input  WIDTH  port A write data.
- a_dout  output  WIDTH  port A read data.
- a_valid  output  1  one-cycle pulse: a_dout carries new read data.
- b_we, b_re, b_addr, b_din, b_dout, b_valid  same as port A, for port B.
- collision  output  1  one-cycle pulse: both ports wrote the same address in the same cycle.

Behaviour:
- Reset (rst=0, async):
  - a_dout, b_dout = 0; a_valid, b_valid, collision = 0; busy = 1.
  - FSM forced to CLEAR; clear counter = 0.
  - Memory contents are not touched asynchronously.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[cnt] and increments cnt. When cnt == DEPTH-1, write the last word and go to READY. busy = 1 throughout. The sweep takes exactly DEPTH cycles after rst deasserts.
  - READY: busy = 0; normal operation. No exit except reset.
- Reset asserted mid-sweep or mid-operation:
  - Outputs clear immediately; the sweep restarts at address 0.
  - Any read still in the pipeline is discarded (no valid pulse).
- While busy = 1:
  - All we/re inputs are ignored; no valid pulses.
  - dout stays 0.
- Port operation (READY), per port, sampled at posedge N:
  - we=1: mem[addr] <= din.
  - re=1: read issued.
  - we=1 and re=1: write happens and the read is issued. Read data follows READ_MODE: 0 returns old mem[addr], 1 returns din.
- Read latency:
  - OUT_REG=0: dout updated and valid=1 after posedge N (visible during cycle N+1).
  - OUT_REG=1: one cycle later (cycle N+2).
  - valid high for exactly one cycle per issued read.
  - Back-to-back reads every cycle are supported; valid stays high continuously.
- dout holds its last value when no read completes; it is never driven to Z.
- Cross-port read-during-write (B reads X while A writes X, same edge, or vice versa):
  - READ_MODE=0: reader gets old data.
  - READ_MODE=1: reader gets the writer's din (bypass).
- Write-write collision (a_we & b_we & a_addr == b_addr, READY):
  - Port A's data is stored.
  - collision pulses high for one cycle, aligned with the write edge (visible cycle N+1).
  - Port B's write is dropped.
  - A simultaneous read of that address on either port follows READ_MODE using A's din.
- Different addresses on the two ports: fully independent, no interaction.
- Address range: ADDR_BUS is sized exactly to DEPTH; no out-of-range handling.

Test Plan:
- Release rst, hold a_re=1 a_addr=5 during sweep -> busy=1 for 16 cycles, no a_valid. After busy falls, read addr 5 -> a_dout=0x00 with a_valid one cycle later.
- OUT_REG=0: A writes 0xA5 to addr 3; next cycle B reads addr 3 -> b_dout=0xA5, b_valid pulse 1 cycle after the read edge. With OUT_REG=1, same stimulus -> 2 cycles.
- READ_MODE=0: mem[7]=0x11; same edge A writes 0x22 to 7 and B reads 7 -> b_dout=0x11. Repeat with READ_MODE=1 -> b_dout=0x22. Either mode, a later read of 7 returns 0x22.
- Same edge A writes 0x3C and B writes 0xC3 to addr 9 -> collision pulses once; a later read of addr 9 returns 0x3C.
- Streaming: A reads addrs 0..15 on consecutive cycles after filling with addr^0xFF -> a_valid high 16 consecutive cycles, data 0xFF..0xF0 in order.
- Assert rst mid-sweep (cycle 8) and mid-read -> outputs 0 immediately, no valid pulse. After release, busy held a full 16 cycles; previously written addr reads 0x00.
